// File: rtl/align_pkg.sv
// Shared constants for the store alignment pipeline: default geometry,
// stage-1 rotation granule and the length/offset encodings.
package align_pkg;

  // Default cache-line width in bytes and byte-lane width in bits.
  localparam int DEF_WIDTH = 32;
  localparam int DEF_N     = 8;

  // Stage 1 rotates in whole granules; stage 2 finishes the residue.
  localparam int S1_GRANULE  = 4;
  localparam int OFF_LO_BITS = $clog2(S1_GRANULE);

  // in_len carries (length - 1), so a byte i is enabled when i < in_len + LEN_BIAS.
  localparam int LEN_BIAS = 1;

endpackage

// File: rtl/rotl_bytes.sv
// Combinational byte rotate-left built as a log-shifter of 2:1 mux stages.
// Only amount bits LO..HI are handled, so the rotate can be split across
// pipeline stages (LO..HI rotate by 2**LO .. 2**HI bytes).

module mux_nbit_2x1 #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sel,
  output logic [W-1:0] y
);

  assign y = sel ? b : a;

endmodule

module rotl_bytes #(
  parameter int WIDTH = 32,
  parameter int N     = 8,
  parameter int LO    = 0,
  parameter int HI    = 4
) (
  input  logic [N*WIDTH-1:0] in_bytes,
  input  logic [HI-LO:0]     amt,
  output logic [N*WIDTH-1:0] out_bytes
);

  localparam int STAGES = HI - LO + 1;
  localparam int TOTAL  = N * WIDTH;

  logic [TOTAL-1:0] stage_s [0:STAGES];

  assign stage_s[0] = in_bytes;

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    localparam int SH = N * (1 << (LO + g));
    logic [TOTAL-1:0] rot_s;

    // Fixed rotate by 2**(LO+g) bytes; the mux picks it when the amount bit is set.
    assign rot_s = {stage_s[g][TOTAL-SH-1:0], stage_s[g][TOTAL-1:TOTAL-SH]};

    mux_nbit_2x1 #(.W(TOTAL)) u_mux (
      .a   (stage_s[g]),
      .b   (rot_s),
      .sel (amt[g]),
      .y   (stage_s[g+1])
    );
  end

  assign out_bytes = stage_s[STAGES];

endmodule

// File: rtl/store_align_rotl.sv
// Two-stage store aligner: rotates right-justified store data to its byte
// offset within a cache line and produces the matching byte enables.
// S1 rotates by whole 4-byte granules, S2 by the remaining 0..3 bytes.
// Optional macro STORE_ALIGN_SPLIT_EN splits the enables into a
// non-wrapped part (out_be) and a wrapped part (out_be_wrap) plus out_split.
module store_align_rotl
  import align_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  parameter  int N     = DEF_N,
  localparam int AMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0]   in_offset,
  input  logic [AMT_W-1:0]   in_len,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N*WIDTH-1:0] out_data,
  output logic [WIDTH-1:0]   out_be
`ifdef STORE_ALIGN_SPLIT_EN
  ,
  output logic               out_split,
  output logic [WIDTH-1:0]   out_be_wrap
`endif
);

  localparam int LO_BITS = OFF_LO_BITS;

  logic               s1_valid_r;
  logic [N*WIDTH-1:0] s1_data_r;
  logic [AMT_W-1:0]   s1_off_r;
  logic [AMT_W-1:0]   s1_len_r;

  logic [N*WIDTH-1:0] s1_rot_s;
  logic [N*WIDTH-1:0] s2_rot_s;
  logic [WIDTH-1:0]   mask_s;
  logic [WIDTH-1:0]   mask_rot_s;
  logic               s2_free_s;
  logic               in_fire_s;

  // S2 can take a new entry when empty or when its current entry leaves.
  assign s2_free_s = !out_valid || out_ready;
  assign in_ready  = !s1_valid_r || s2_free_s;
  assign in_fire_s = in_valid && in_ready;

  // Coarse rotate of the incoming data by the granule part of the offset.
  rotl_bytes #(.WIDTH(WIDTH), .N(N), .LO(LO_BITS), .HI(AMT_W-1)) u_rot_s1 (
    .in_bytes  (in_data),
    .amt       (in_offset[AMT_W-1:LO_BITS]),
    .out_bytes (s1_rot_s)
  );

  // Fine rotate of the S1 data by the residual offset bits.
  rotl_bytes #(.WIDTH(WIDTH), .N(N), .LO(0), .HI(LO_BITS-1)) u_rot_s2 (
    .in_bytes  (s1_data_r),
    .amt       (s1_off_r[LO_BITS-1:0]),
    .out_bytes (s2_rot_s)
  );

  // Enable mask reuses the rotator with one-bit lanes over the full offset.
  rotl_bytes #(.WIDTH(WIDTH), .N(1), .LO(0), .HI(AMT_W-1)) u_rot_be (
    .in_bytes  (mask_s),
    .amt       (s1_off_r),
    .out_bytes (mask_rot_s)
  );

  // Unrotated enable mask: bytes 0..len set.
  always_comb begin
    mask_s = {WIDTH{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      if (i < int'(s1_len_r) + LEN_BIAS) begin
        mask_s[i] = 1'b1;
      end else begin
        mask_s[i] = 1'b0;
      end
    end
  end

`ifdef STORE_ALIGN_SPLIT_EN
  logic [WIDTH-1:0] keep_s;
  logic [AMT_W:0]   sum_s;

  // WIDTH is a power of two, so offset+len >= WIDTH is exactly the carry bit.
  assign sum_s = {1'b0, s1_off_r} + {1'b0, s1_len_r};

  // Rotated positions at or above the offset did not wrap past the line end.
  always_comb begin
    keep_s = {WIDTH{1'b0}};
    for (int j = 0; j < WIDTH; j++) begin
      if (j >= int'(s1_off_r)) begin
        keep_s[j] = 1'b1;
      end else begin
        keep_s[j] = 1'b0;
      end
    end
  end
`endif

  // Stage 1 register: accepts a request whenever in_ready is high.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_data_r  <= {(N*WIDTH){1'b0}};
      s1_off_r   <= {AMT_W{1'b0}};
      s1_len_r   <= {AMT_W{1'b0}};
    end else if (in_fire_s) begin
      s1_valid_r <= 1'b1;
      s1_data_r  <= s1_rot_s;
      s1_off_r   <= in_offset;
      s1_len_r   <= in_len;
    end else if (s2_free_s) begin
      s1_valid_r <= 1'b0;
    end
  end

  // Stage 2 / output register: holds while the consumer stalls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_data    <= {(N*WIDTH){1'b0}};
      out_be      <= {WIDTH{1'b0}};
`ifdef STORE_ALIGN_SPLIT_EN
      out_split   <= 1'b0;
      out_be_wrap <= {WIDTH{1'b0}};
`endif
    end else if (s2_free_s) begin
      out_valid <= s1_valid_r;
      if (s1_valid_r) begin
        out_data    <= s2_rot_s;
`ifdef STORE_ALIGN_SPLIT_EN
        out_be      <= mask_rot_s & keep_s;
        out_be_wrap <= mask_rot_s & ~keep_s;
        out_split   <= sum_s[AMT_W];
`else
        out_be      <= mask_rot_s;
`endif
      end
    end
  end

endmodule

// File: tb/tb_store_align_rotl.sv
// Self-checking bench for store_align_rotl (WIDTH=32, N=8); a scoreboard
// queue holds expected results pushed at input transfer and compared at
// output transfer. Honors STORE_ALIGN_SPLIT_EN when defined.
module tb_store_align_rotl;

  localparam int WIDTH = 32;
  localparam int N     = 8;
  localparam int AMT_W = 5;

  logic               clk;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic [N*WIDTH-1:0] in_data;
  logic [AMT_W-1:0]   in_offset;
  logic [AMT_W-1:0]   in_len;
  logic               out_valid;
  logic               out_ready;
  logic [N*WIDTH-1:0] out_data;
  logic [WIDTH-1:0]   out_be;
`ifdef STORE_ALIGN_SPLIT_EN
  logic               out_split;
  logic [WIDTH-1:0]   out_be_wrap;
`endif

  typedef struct packed {
    logic [N*WIDTH-1:0] data;
    logic [WIDTH-1:0]   be;
    logic [WIDTH-1:0]   wrap;
    logic               split;
  } res_t;

  res_t exp_q[$];
  res_t obs_q[$];
  int   checks;
  int   passed;
  bit   last_in_fire;
  bit   last_out_fire;

  store_align_rotl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_offset   (in_offset),
    .in_len      (in_len),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_be      (out_be)
`ifdef STORE_ALIGN_SPLIT_EN
    ,
    .out_split   (out_split),
    .out_be_wrap (out_be_wrap)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: place byte i at (i+off) mod WIDTH and mark its enable.
  function automatic res_t model(logic [N*WIDTH-1:0] d, logic [AMT_W-1:0] off, logic [AMT_W-1:0] len);
    res_t r;
    r = '0;
    for (int i = 0; i < WIDTH; i++) begin
      int j;
      j = (i + int'(off)) % WIDTH;
      r.data[j*N +: N] = d[i*N +: N];
      if (i <= int'(len)) begin
        if (i + int'(off) >= WIDTH) r.wrap[j] = 1'b1;
        else r.be[j] = 1'b1;
      end
    end
    r.split = ((int'(off) + int'(len)) >= WIDTH);
`ifndef STORE_ALIGN_SPLIT_EN
    r.be    = r.be | r.wrap;
    r.wrap  = '0;
    r.split = 1'b0;
`endif
    return r;
  endfunction

  function automatic res_t observe();
    res_t r;
    r = '0;
    r.data = out_data;
    r.be   = out_be;
`ifdef STORE_ALIGN_SPLIT_EN
    r.wrap  = out_be_wrap;
    r.split = out_split;
`endif
    return r;
  endfunction

  // One clock: sample transfers before the edge, record into the scoreboard.
  task automatic tick();
    #1;
    last_in_fire  = in_valid && in_ready && rst_n;
    last_out_fire = out_valid && out_ready && rst_n;
    if (!rst_n) begin
      exp_q.delete();
      obs_q.delete();
    end else begin
      if (last_in_fire) exp_q.push_back(model(in_data, in_offset, in_len));
      if (last_out_fire) obs_q.push_back(observe());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b want=0", out_valid); else passed++;
    checks++;
    if (out_data !== '0) $display("FAIL reset_out_data got=%h want=0", out_data); else passed++;
    checks++;
    if (out_be !== '0) $display("FAIL reset_out_be got=%h want=0", out_be); else passed++;
    checks++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b want=1", in_ready); else passed++;
  endtask

  task automatic test_directed();
    logic [N*WIDTH-1:0] d_t   [4];
    logic [AMT_W-1:0]   off_t [4];
    logic [AMT_W-1:0]   len_t [4];
    logic [N*WIDTH-1:0] xd_t  [4];
    logic [WIDTH-1:0]   xbe_t [4];
    logic [N*WIDTH-1:0] one;
    res_t o, e;
    int budget;
    one = 1;
    d_t[0] = 256'hDDCCBBAA; off_t[0] = 5'd0;  len_t[0] = 5'd3;  xd_t[0] = 256'hDDCCBBAA;
    d_t[1] = 256'hBBAA;     off_t[1] = 5'd5;  len_t[1] = 5'd1;  xd_t[1] = 256'hBBAA << 40;
    d_t[2] = 256'hDDCCBBAA; off_t[2] = 5'd30; len_t[2] = 5'd3;  xd_t[2] = (256'hBBAA << 240) | 256'hDDCC;
    d_t[3] = one;           off_t[3] = 5'd7;  len_t[3] = 5'd31; xd_t[3] = one << 56;
`ifdef STORE_ALIGN_SPLIT_EN
    xbe_t[0] = 32'h0000000F; xbe_t[1] = 32'h00000060; xbe_t[2] = 32'hC0000000; xbe_t[3] = 32'hFFFFFF80;
`else
    xbe_t[0] = 32'h0000000F; xbe_t[1] = 32'h00000060; xbe_t[2] = 32'hC0000003; xbe_t[3] = 32'hFFFFFFFF;
`endif
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; in_data = d_t[k]; in_offset = off_t[k]; in_len = len_t[k];
      tick();
      in_valid = 1'b0;
      tick();
      checks++;
      if (out_valid !== 1'b1) $display("FAIL directed%0d_latency out_valid got=%b want=1", k, out_valid); else passed++;
      checks++;
      if (out_data !== xd_t[k]) $display("FAIL directed%0d_data got=%h want=%h", k, out_data, xd_t[k]); else passed++;
      checks++;
      if (out_be !== xbe_t[k]) $display("FAIL directed%0d_be got=%h want=%h", k, out_be, xbe_t[k]); else passed++;
`ifdef STORE_ALIGN_SPLIT_EN
      if (k == 2) begin
        checks++;
        if (out_be_wrap !== 32'h00000003 || out_split !== 1'b1)
          $display("FAIL directed_wrap_split got wrap=%h split=%b want wrap=00000003 split=1", out_be_wrap, out_split);
        else passed++;
      end
`endif
      tick();
    end
    budget = 0;
    while (obs_q.size() < exp_q.size() && budget < 50) begin tick(); budget++; end
    checks++;
    if (obs_q.size() < exp_q.size()) $display("FAIL directed_drain outputs got=%0d want=%0d", obs_q.size(), exp_q.size()); else passed++;
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      checks++;
      if (exp_q.size() == 0) $display("FAIL directed_sb extra output data=%h be=%h", o.data, o.be);
      else begin
        e = exp_q.pop_front();
        if (o !== e) $display("FAIL directed_sb got data=%h be=%h wrap=%h split=%b want data=%h be=%h wrap=%h split=%b",
                              o.data, o.be, o.wrap, o.split, e.data, e.be, e.wrap, e.split);
        else passed++;
      end
    end
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    res_t o, e;
    int budget;
    for (int c = 0; c < 120; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = (c < 20) ? 1'b1 : ($urandom_range(0, 3) != 0);
      in_data   = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      in_offset = AMT_W'($urandom_range(0, WIDTH-1));
      in_len    = AMT_W'($urandom_range(0, WIDTH-1));
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    budget = 0;
    while (obs_q.size() < exp_q.size() && budget < 50) begin tick(); budget++; end
    checks++;
    if (obs_q.size() < exp_q.size()) $display("FAIL b2b_drain outputs got=%0d want=%0d", obs_q.size(), exp_q.size()); else passed++;
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      checks++;
      if (exp_q.size() == 0) $display("FAIL b2b_sb extra output data=%h be=%h", o.data, o.be);
      else begin
        e = exp_q.pop_front();
        if (o !== e) $display("FAIL b2b_sb got data=%h be=%h wrap=%h split=%b want data=%h be=%h wrap=%h split=%b",
                              o.data, o.be, o.wrap, o.split, e.data, e.be, e.wrap, e.split);
        else passed++;
      end
    end
    exp_q.delete();
  endtask

  task automatic test_backpressure();
    res_t o, e;
    logic [N*WIDTH-1:0] held_data;
    logic [WIDTH-1:0]   held_be;
    int sent;
    int budget;
    sent = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      in_valid  = (sent < 3);
      in_data   = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      in_offset = AMT_W'(3 + 9 * sent);
      in_len    = AMT_W'(2 + 5 * sent);
      tick();
      if (last_in_fire) sent++;
      if (c == 1) begin
        held_data = out_data;
        held_be   = out_be;
      end
      if (c >= 2) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== held_data || out_be !== held_be)
          $display("FAIL bp_hold cycle%0d got valid=%b data=%h be=%h want valid=1 data=%h be=%h",
                   c, out_valid, out_data, out_be, held_data, held_be);
        else passed++;
      end
    end
    checks++;
    if (sent !== 2 || in_ready !== 1'b0) $display("FAIL bp_full got accepted=%0d in_ready=%b want accepted=2 in_ready=0", sent, in_ready); else passed++;
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      in_valid = (sent < 3);
      tick();
      if (last_in_fire) sent++;
      checks++;
      if (last_out_fire !== 1'b1) $display("FAIL bp_release cycle%0d output transfer got=%b want=1", c, last_out_fire); else passed++;
    end
    in_valid = 1'b0;
    budget = 0;
    while (obs_q.size() < exp_q.size() && budget < 50) begin tick(); budget++; end
    checks++;
    if (obs_q.size() != 3 || exp_q.size() != 3) $display("FAIL bp_count got outputs=%0d inputs=%0d want 3/3", obs_q.size(), exp_q.size()); else passed++;
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      checks++;
      if (exp_q.size() == 0) $display("FAIL bp_sb extra output data=%h be=%h", o.data, o.be);
      else begin
        e = exp_q.pop_front();
        if (o !== e) $display("FAIL bp_sb got data=%h be=%h wrap=%h split=%b want data=%h be=%h wrap=%h split=%b",
                              o.data, o.be, o.wrap, o.split, e.data, e.be, e.wrap, e.split);
        else passed++;
      end
    end
    exp_q.delete();
  endtask

  task automatic test_reset_midflight();
    res_t o, e;
    bit stale;
    int budget;
    out_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      in_valid  = 1'b1;
      in_data   = {8{32'h5A5A0000 + 32'(c)}};
      in_offset = AMT_W'(6 + c);
      in_len    = AMT_W'(4);
      tick();
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || in_ready !== 1'b1)
      $display("FAIL midreset_state got valid=%b data=%h in_ready=%b want valid=0 data=0 in_ready=1", out_valid, out_data, in_ready);
    else passed++;
    out_ready = 1'b1;
    stale = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (out_valid !== 1'b0) stale = 1'b1;
    end
    checks++;
    if (stale) $display("FAIL midreset_stale got stale output=1 want=0"); else passed++;
    in_valid  = 1'b1;
    in_data   = {8{32'h13579BDF}};
    in_offset = AMT_W'(11);
    in_len    = AMT_W'(25);
    tick();
    in_valid = 1'b0;
    budget = 0;
    while (obs_q.size() < exp_q.size() && budget < 50) begin tick(); budget++; end
    checks++;
    if (obs_q.size() != 1 || exp_q.size() != 1) $display("FAIL midreset_count got outputs=%0d inputs=%0d want 1/1", obs_q.size(), exp_q.size()); else passed++;
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      checks++;
      if (exp_q.size() == 0) $display("FAIL midreset_sb extra output data=%h be=%h", o.data, o.be);
      else begin
        e = exp_q.pop_front();
        if (o !== e) $display("FAIL midreset_sb got data=%h be=%h wrap=%h split=%b want data=%h be=%h wrap=%h split=%b",
                              o.data, o.be, o.wrap, o.split, e.data, e.be, e.wrap, e.split);
        else passed++;
      end
    end
    exp_q.delete();
  endtask

  initial begin
    checks    = 0;
    passed    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_offset = '0;
    in_len    = '0;
    out_ready = 1'b1;
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
